// File: rtl/reply_arbiter_pkg.sv
// Shared types and helpers for the reply FIFO arbiter.
package reply_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FINISH = 2'd2
   } state_t;

   localparam int LEN_W_DEF = 9;

   // Low bit of field i in a vector packed with w-bit fields.
   function automatic int lsb(input int i, input int w);
      return i * w;
   endfunction

endpackage

// File: rtl/reply_arbiter_if.sv
// Reply producer and FIFO write-port bundle; master = arbiter side, slave = producers and FIFO.
interface reply_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int LEN_W = 9
);
   logic [N_REQ-1:0]       req;
   logic [N_REQ*LEN_W-1:0] req_len;
   logic [N_REQ*8-1:0]     src_data;
   logic [N_REQ-1:0]       src_valid;
   logic [N_REQ-1:0]       src_ready;
   logic [N_REQ-1:0]       grant;
   logic [N_REQ-1:0]       done;
   logic                   err_oversize;
   logic                   fifo_wr_en;
   logic [7:0]             fifo_wr_data;
   logic                   fifo_full;
   logic [LEN_W-1:0]       fifo_free;
   logic                   busy;

   modport master (
      input  req, req_len, src_data, src_valid, fifo_full, fifo_free,
      output src_ready, grant, done, err_oversize, fifo_wr_en, fifo_wr_data, busy
   );

   modport slave (
      output req, req_len, src_data, src_valid, fifo_full, fifo_free,
      input  src_ready, grant, done, err_oversize, fifo_wr_en, fifo_wr_data, busy
   );
endinterface

// File: rtl/reply_arbiter_rr_pick.sv
// Combinational round-robin picker: first req&elig bit searching upward from ptr+1.
module rr_pick #(
   parameter int N     = 4,
   parameter int PTR_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [N-1:0]     elig,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     pick,
   output logic             valid
);

   always_comb begin
      pick  = '0;
      valid = 1'b0;
      for (int k = 1; k <= N; k++) begin
         logic [PTR_W-1:0] idx;
         idx = PTR_W'((int'(ptr) + k) % N);
         if (!valid && req[idx] && elig[idx]) begin
            pick[idx] = 1'b1;
            valid     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/reply_arbiter.sv
// Round-robin whole-packet arbiter in front of the reply FIFO.
// Optional REPLY_ARB_SKIP_EN: grant the first fitting requester instead of waiting head-of-line.
//
// state  | meaning
// IDLE   | choose a candidate, grant once its packet fits
// STREAM | pass the granted requester's bytes into the FIFO
// FINISH | done pulse cycle; requests are not evaluated
module reply_arbiter import reply_arb_pkg::*; #(
   parameter int N_REQ = 4,
   parameter int DEPTH = 256,
   parameter int LEN_W = LEN_W_DEF
) (
   input logic             clk,
   input logic             rst_n,
   reply_arbiter_if.master bus
);

   localparam int               PTR_W   = $clog2(N_REQ);
   localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

   state_t           state;
   logic [N_REQ-1:0] grant;
   logic [N_REQ-1:0] done;
   logic             err_oversize;
   logic             busy;
   logic [LEN_W-1:0] remaining;
   logic [PTR_W-1:0] ptr;

   logic [N_REQ-1:0] pick;
   logic             pick_valid;
   logic [PTR_W-1:0] pick_idx;
   logic [LEN_W-1:0] sel_len;
   logic [7:0]       sel_data;
   logic             sel_valid;
   logic             wr_en;

`ifdef REPLY_ARB_SKIP_EN
   logic [N_REQ-1:0] fit_mask;
   logic [N_REQ-1:0] skipped;
   logic [N_REQ-1:0] pick_norm, pick_skip;
   logic             valid_norm, valid_skip;

   always_comb begin
      fit_mask = '0;
      for (int i = 0; i < N_REQ; i++) begin
         fit_mask[i] = (bus.req_len[lsb(i, LEN_W) +: LEN_W] > DEPTH_L) ||
                       (bus.req_len[lsb(i, LEN_W) +: LEN_W] <= bus.fifo_free);
      end
   end

   rr_pick #(.N(N_REQ), .PTR_W(PTR_W)) u_pick_skip (
      .req(bus.req & skipped), .elig(fit_mask), .ptr(ptr),
      .pick(pick_skip), .valid(valid_skip)
   );

   rr_pick #(.N(N_REQ), .PTR_W(PTR_W)) u_pick (
      .req(bus.req), .elig(fit_mask), .ptr(ptr),
      .pick(pick_norm), .valid(valid_norm)
   );

   // Previously skipped requesters win outright once they fit, bounding starvation.
   assign pick       = valid_skip ? pick_skip : pick_norm;
   assign pick_valid = valid_skip | valid_norm;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skipped <= '0;
      end else if (state == IDLE && pick_valid) begin
         skipped <= (skipped | (bus.req & ~fit_mask)) & ~pick & bus.req;
      end else begin
         skipped <= skipped & bus.req;
      end
   end
`else
   rr_pick #(.N(N_REQ), .PTR_W(PTR_W)) u_pick (
      .req(bus.req), .elig({N_REQ{1'b1}}), .ptr(ptr),
      .pick(pick), .valid(pick_valid)
   );
`endif

   always_comb begin
      sel_len   = '0;
      sel_data  = '0;
      sel_valid = 1'b0;
      pick_idx  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick[i]) begin
            sel_len  = sel_len | bus.req_len[lsb(i, LEN_W) +: LEN_W];
            pick_idx = PTR_W'(i);
         end
         if (grant[i]) begin
            sel_data  = sel_data | bus.src_data[lsb(i, 8) +: 8];
            sel_valid = sel_valid | bus.src_valid[i];
         end
      end
   end

   assign wr_en = (state == STREAM) && sel_valid && !bus.fifo_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         grant        <= '0;
         done         <= '0;
         err_oversize <= 1'b0;
         busy         <= 1'b0;
         remaining    <= '0;
         ptr          <= PTR_W'(N_REQ - 1);
      end else begin
         done         <= '0;
         err_oversize <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  if (sel_len == '0) begin
                     grant <= pick;
                     done  <= pick;
                     ptr   <= pick_idx;
                     busy  <= 1'b1;
                     state <= FINISH;
                  end else if (sel_len > DEPTH_L) begin
                     done         <= pick;
                     err_oversize <= 1'b1;
                     ptr          <= pick_idx;
                     busy         <= 1'b1;
                     state        <= FINISH;
                  end else if (sel_len <= bus.fifo_free) begin
                     grant     <= pick;
                     remaining <= sel_len;
                     ptr       <= pick_idx;
                     busy      <= 1'b1;
                     state     <= STREAM;
                  end
               end
            end
            STREAM: begin
               if (wr_en) begin
                  remaining <= remaining - LEN_W'(1);
                  if (remaining == LEN_W'(1)) begin
                     grant <= '0;
                     done  <= grant;
                     state <= FINISH;
                  end
               end
            end
            FINISH: begin
               grant <= '0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               grant <= '0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.grant        = grant;
   assign bus.done         = done;
   assign bus.err_oversize = err_oversize;
   assign bus.busy         = busy;
   assign bus.src_ready    = (state == STREAM) ? (grant & {N_REQ{~bus.fifo_full}}) : '0;
   assign bus.fifo_wr_en   = wr_en;
   assign bus.fifo_wr_data = (state == STREAM) ? sel_data : 8'h00;

endmodule

// File: tb/tb_reply_arbiter.sv
// Directed bench for reply_arbiter with a byte scoreboard on the FIFO write port.
module tb_reply_arbiter;

   typedef struct packed {
      logic [1:0] lane;
      logic [7:0] data;
   } item_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;
   int   wr_cnt = 0;
   logic [3:0] vmask = 4'hF;
   item_t      src_q[$];
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   reply_arbiter_if #(.N_REQ(4), .LEN_W(9)) bus ();

   reply_arbiter #(.N_REQ(4), .DEPTH(256), .LEN_W(9)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.master)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [8:0] len);
      bus.req_len[i*9 +: 9] = len;
      bus.req[i] = 1'b1;
   endtask

   task automatic push_pkt(input logic [1:0] lane, input int n, input logic [7:0] base);
      for (int k = 0; k < n; k++) begin
         src_q.push_back({lane, base + 8'(k)});
         exp_q.push_back(base + 8'(k));
      end
   endtask

   // Ticks until a done pulse (bounded), checks it, and drops the finished requests.
   task automatic wait_done(input logic [3:0] exp, input string tag, output int n);
      n = 0;
      while (bus.done == 4'h0 && n < 64) begin
         tick();
         n++;
      end
      check(tag, 32'(bus.done), 32'(exp));
      bus.req = bus.req & ~exp;
   endtask

   // Producer: presents the head byte on its lane; other lanes carry junk with valid low.
   initial begin
      logic hs;
      bus.src_valid = '0;
      bus.src_data  = {4{8'hEE}};
      forever begin
         @(negedge clk);
         hs = 1'b0;
         if (src_q.size() > 0)
            hs = bus.src_valid[src_q[0].lane] & bus.src_ready[src_q[0].lane];
         @(posedge clk);
         #2;
         if (hs && src_q.size() > 0) void'(src_q.pop_front());
         bus.src_valid = '0;
         bus.src_data  = {4{8'hEE}};
         if (src_q.size() > 0) begin
            bus.src_valid[src_q[0].lane]      = vmask[src_q[0].lane];
            bus.src_data[src_q[0].lane*8 +: 8] = src_q[0].data;
         end
      end
   end

   // Scoreboard on the FIFO write port.
   always @(negedge clk) begin
      if (bus.fifo_wr_en === 1'b1) begin
         wr_cnt++;
         if (exp_q.size() == 0) check("wr_unexpected", 32'(bus.fifo_wr_data), 32'h0);
         else check("wr_data", 32'(bus.fifo_wr_data), 32'(exp_q.pop_front()));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, base;
      logic [0:11] vpat;
      logic [0:11] fpat;
      bus.req       = '0;
      bus.req_len   = '0;
      bus.fifo_full = 1'b0;
      bus.fifo_free = 9'd256;

      #3;
      check("rst_grant", 32'(bus.grant), 0);
      check("rst_done", 32'(bus.done), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_wr_en", 32'(bus.fifo_wr_en), 0);
      check("rst_err", 32'(bus.err_oversize), 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Single packet from requester 0
      push_pkt(2'd0, 3, 8'hA1);
      set_req(0, 9'd3);
      tick();
      check("t1_grant", 32'(bus.grant), 32'h1);
      check("t1_busy", 32'(bus.busy), 1);
      wait_done(4'h1, "t1_done", n);
      check("t1_cycles", 32'(n), 3);
      check("t1_grant_drop", 32'(bus.grant), 0);
      check("t1_err", 32'(bus.err_oversize), 0);
      tick();
      check("t1_busy_idle", 32'(bus.busy), 0);
      check("t1_done_once", 32'(bus.done), 0);
      check("t1_writes", 32'(wr_cnt), 3);

      // Contention 1 vs 2, then 1 re-requests while 2 waits
      push_pkt(2'd1, 2, 8'hB1);
      push_pkt(2'd2, 2, 8'hC1);
      push_pkt(2'd1, 1, 8'hB3);
      set_req(1, 9'd2);
      set_req(2, 9'd2);
      tick();
      check("t2_grant1", 32'(bus.grant), 32'h2);
      wait_done(4'h2, "t2_done1", n);
      check("t2_cycles", 32'(n), 2);
      tick();
      set_req(1, 9'd1);
      check("t2_idle_gap", 32'(bus.grant), 0);
      tick();
      check("t2_grant2", 32'(bus.grant), 32'h4);
      wait_done(4'h4, "t2_done2", n);
      tick();
      tick();
      check("t2_grant1_again", 32'(bus.grant), 32'h2);
      wait_done(4'h2, "t2_done3", n);
      tick();
      tick();
      check("t2_writes", 32'(wr_cnt), 8);

      // Fit check: requester 0 needs 10, only 5 free; requester 1 needs 4
      bus.fifo_free = 9'd5;
`ifdef REPLY_ARB_SKIP_EN
      push_pkt(2'd1, 4, 8'h50);
      push_pkt(2'd0, 10, 8'h60);
`else
      push_pkt(2'd0, 10, 8'h60);
      push_pkt(2'd1, 4, 8'h50);
`endif
      set_req(0, 9'd10);
      set_req(1, 9'd4);
`ifdef REPLY_ARB_SKIP_EN
      tick();
      check("t3_skip_grant1", 32'(bus.grant), 32'h2);
      wait_done(4'h2, "t3_skip_done1", n);
      tick();
      tick();
      check("t3_skip_wait0", 32'(bus.grant), 0);
      bus.fifo_free = 9'd10;
      tick();
      check("t3_skip_grant0", 32'(bus.grant), 32'h1);
      wait_done(4'h1, "t3_skip_done0", n);
      tick();
      tick();
`else
      for (int c = 0; c < 3; c++) begin
         tick();
         check("t3_hol_wait", 32'(bus.grant), 0);
         check("t3_hol_busy", 32'(bus.busy), 0);
      end
      bus.fifo_free = 9'd10;
      tick();
      check("t3_grant0", 32'(bus.grant), 32'h1);
      wait_done(4'h1, "t3_done0", n);
      check("t3_cycles", 32'(n), 10);
      tick();
      tick();
      check("t3_grant1", 32'(bus.grant), 32'h2);
      wait_done(4'h2, "t3_done1", n);
      tick();
      tick();
`endif
      check("t3_writes", 32'(wr_cnt), 22);
      bus.fifo_free = 9'd256;

      // Oversize request is rejected
      set_req(3, 9'd300);
      tick();
      check("t4_done", 32'(bus.done), 32'h8);
      check("t4_err", 32'(bus.err_oversize), 1);
      check("t4_no_grant", 32'(bus.grant), 0);
      bus.req[3] = 1'b0;
      tick();
      check("t4_err_once", 32'(bus.err_oversize), 0);
      check("t4_done_once", 32'(bus.done), 0);
      tick();

      // Zero-length request: grant and done together
      set_req(2, 9'd0);
      tick();
      check("t4_zero_grant", 32'(bus.grant), 32'h4);
      check("t4_zero_done", 32'(bus.done), 32'h4);
      bus.req[2] = 1'b0;
      tick();
      check("t4_zero_clear", 32'(bus.grant), 0);
      tick();
      check("t4_writes", 32'(wr_cnt), 22);

      // Stalls from src_valid gaps and a forced fifo_full
      vpat = 12'b1011_0111_1111;
      fpat = 12'b0011_0000_0000;
      push_pkt(2'd0, 4, 8'hD1);
      set_req(0, 9'd4);
      tick();
      check("t5_grant", 32'(bus.grant), 32'h1);
      n = 0;
      while (bus.done == 4'h0 && n < 12) begin
         vmask[0]      = vpat[n];
         bus.fifo_full = fpat[n];
         @(negedge clk);
         if (fpat[n]) begin
            check("t5_ready_full", 32'(bus.src_ready), 0);
            check("t5_wr_full", 32'(bus.fifo_wr_en), 0);
         end
         tick();
         n++;
      end
      vmask         = 4'hF;
      bus.fifo_full = 1'b0;
      check("t5_done", 32'(bus.done), 32'h1);
      bus.req[0] = 1'b0;
      check("t5_writes", 32'(wr_cnt), 26);
      check("t5_sb_empty", 32'(exp_q.size()), 0);
      tick();
      tick();

      // Reset in the middle of a 5-byte packet
      src_q.push_back({2'd0, 8'hE1});
      src_q.push_back({2'd0, 8'hE2});
      src_q.push_back({2'd0, 8'hE3});
      src_q.push_back({2'd0, 8'hE4});
      src_q.push_back({2'd0, 8'hE5});
      exp_q.push_back(8'hE1);
      exp_q.push_back(8'hE2);
      base = wr_cnt;
      set_req(0, 9'd5);
      n = 0;
      while (wr_cnt < base + 2 && n < 20) begin
         tick();
         n++;
      end
      check("t6_two_written", 32'(wr_cnt - base), 2);
      rst_n = 1'b0;
      #1;
      check("t6_rst_grant", 32'(bus.grant), 0);
      check("t6_rst_wr_en", 32'(bus.fifo_wr_en), 0);
      check("t6_rst_ready", 32'(bus.src_ready), 0);
      check("t6_rst_busy", 32'(bus.busy), 0);
      bus.req = '0;
      src_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      push_pkt(2'd0, 1, 8'hF1);
      push_pkt(2'd3, 1, 8'hF2);
      set_req(0, 9'd1);
      set_req(3, 9'd1);
      tick();
      check("t6_prio0", 32'(bus.grant), 32'h1);
      wait_done(4'h1, "t6_done0", n);
      tick();
      tick();
      check("t6_grant3", 32'(bus.grant), 32'h8);
      wait_done(4'h8, "t6_done3", n);
      tick();
      tick();
      check("t6_writes", 32'(wr_cnt - base), 4);
      check("t6_sb_empty", 32'(exp_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/reply_arbiter.md
Name: reply_arbiter

Overview:
Shares the single reply FIFO between N_REQ reply producers (command decoder, JTAG shift engine, error/status reporter, etc.). Each producer requests to write a whole reply packet of declared length. The arbiter grants round-robin, but only when the FIFO has room for the entire packet, so packets are never split or interleaved. Once granted, it streams that requester's bytes into the FIFO write port. Sits between the reply producers and reply_fifo; the UART TX drains the FIFO independently.

Parameters:
N_REQ, 4, number of requesters (2..8)
DEPTH, 256, reply FIFO depth; must match the FIFO instance
LEN_W, 9, packet length / free-count width (clog2(DEPTH)+1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req  in  N_REQ  per-requester packet request; held high until its done pulse
req_len  in  N_REQ*LEN_W  packed lengths, requester i at [i*LEN_W +: LEN_W]; stable while req[i] is high
src_data  in  N_REQ*8  packed byte streams, requester i at [i*8 +: 8]
src_valid  in  N_REQ  byte valid per requester
src_ready  out  N_REQ  byte accepted per requester
grant  out  N_REQ  one-hot, high for the whole packet
done  out  N_REQ  one-cycle pulse after the last byte is written or the request is rejected
err_oversize  out  1  one-cycle pulse when the granted req_len exceeds DEPTH
fifo_wr_en  out  1  FIFO write enable
fifo_wr_data  out  8  FIFO write data
fifo_full  in  1  FIFO full
fifo_free  in  LEN_W  FIFO free entries
busy  out  1  high when not in IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer set so requester 0 has first priority; remaining-byte counter 0.
- IDLE:
  - Candidate = first requester with req high, searching from (last_granted+1) mod N_REQ.
  - req_len == 0: grant and done pulse together next cycle; no write; back to IDLE.
  - req_len > DEPTH: done[i] and err_oversize pulse next cycle; no grant; pointer advances past i.
  - req_len <= fifo_free: next cycle grant[i]=1, latch remaining=req_len, state STREAM.
  - Otherwise: wait in IDLE with no skipping (head-of-line fairness); re-evaluate every cycle.
- STREAM:
  - src_ready[g] = ~fifo_full; all other src_ready = 0.
  - fifo_wr_en = src_valid[g] & ~fifo_full; fifo_wr_data = src_data[g] (combinational pass-through, zero latency).
  - Each write decrements remaining by 1.
  - On the write taking remaining from 1 to 0: that same cycle is the final write. Next cycle: grant drops, done[g] pulses, pointer = g, state IDLE.
- Minimum 1 IDLE cycle between packets, so fifo_free reflects the previous packet's final write before the next fit check.
- fifo_full while streaming (not expected; reserved by the fit check) stalls the stream with no data loss.
- src_valid low while streaming: stall indefinitely; no timeout.
- Dropping req mid-packet is a protocol violation. The arbiter completes only on byte count.
- rst_n assertion mid-packet: immediate return to IDLE and outputs cleared. The partial packet already in the FIFO is the FIFO's reset responsibility.
- All arithmetic is unsigned, LEN_W bits. The comparison req_len <= fifo_free is full-width.

Optional Feature:
REPLY_ARB_SKIP_EN:
- Defined: in IDLE, requesters whose packet does not fit are skipped, and the first fitting requester in round-robin order is granted. A skipped requester gets absolute priority once it becomes fittable again, which bounds starvation.
- Undefined: strict head-of-line waiting as described above.

Decomposition:
- Package reply_arb_pkg:
  - state enum {IDLE, STREAM, FINISH}
  - LEN_W default
  - helper function for the packed-slice index
- Sub-module rr_pick: combinational round-robin priority picker. Inputs are the request vector, eligibility mask and pointer; output is a one-hot pick plus a valid flag. Reused by other arbiters in the bridge.

Test Plan:
- req[0], len=3, fifo_free=256, src_valid held 1, bytes 0xA1,0xA2,0xA3:
  - grant[0] the cycle after req
  - 3 consecutive fifo_wr_en with those bytes
  - done[0] the cycle after the last write; busy back to 0
- req[1] and req[2] together, each len=2, pointer at 0:
  - requester 1 is served first, then 1 IDLE cycle, then requester 2
  - next contention of 1 vs 2 grants 2 first
- req[0] len=10, fifo_free=5:
  - no grant
  - free raised to 10: grant the next cycle
  - with SKIP_EN and req[1] len=4: requester 1 is granted while 0 waits
- req[3] len=300:
  - err_oversize and done[3] pulse once; no fifo_wr_en; no grant
- Streaming len=4 with src_valid toggled 1,0,1,1,0,1 and fifo_full forced 1 for 2 cycles:
  - exactly 4 writes, in order, with no duplicates
  - src_ready low while full
- rst_n pulsed low after 2 of 5 bytes:
  - all outputs 0 asynchronously; state IDLE; on release, requester 0 has priority again
